fifo_umbral: RTL and testbench
==============================

Name: fifo_umbral

Overview:
- Synchronous FIFO at the consumer end of the flow-control state machine.
- Stores data words and reports fill-level flags.
- Accepts the programmable low/high thresholds (bajo/alto) that the state machine drives. Its empty flag feeds that machine's empty_fifos vector, one bit per instance.
- Sits between the data-path demux and the arbiter; one instance per virtual-channel queue.

Parameters:
- DATA_WIDTH, 6, width of each stored word.
- ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH = 8 entries.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low. reset==0 clears all state immediately; release is sampled on clk.
- init  input  1  synchronous soft clear of contents (see Behaviour).
- bajo  input  ADDR_WIDTH  low threshold from the state machine.
- alto  input  ADDR_WIDTH  high threshold from the state machine.
- push  input  1  write request.
- data_in  input  DATA_WIDTH  write data, sampled with push.
- pop  input  1  read request.
- data_out  output  DATA_WIDTH  registered read data.
- valid_out  output  1  data_out holds a word popped on the previous edge.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- almost_empty  output  1  count <= bajo.
- almost_full  output  1  count >= alto, and alto != 0.
- error  output  1  sticky overflow/underflow indicator.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.

Behaviour:
- **Reset (reset==0, asynchronous):**
  - wr_ptr=0, rd_ptr=0, count=0.
  - data_out=0, valid_out=0, error=0.
  - Resulting flags: empty=1, full=0, almost_empty=1, almost_full=0.
  - Memory contents are don't-care.
- **init==1 at posedge (reset released):**
  - Pointers and count go to 0; error=0, valid_out=0; data_out holds its value.
  - push and pop in that cycle are ignored.
  - init has priority over all other operations.
- **Acceptance, evaluated on the registered count before the edge:**
  - pop_ok = pop && !empty.
  - push_ok = push && (!full || pop_ok).
- **push_ok:** mem[wr_ptr] <= data_in; wr_ptr increments and wraps modulo DEPTH.
- **pop_ok:**
  - data_out <= mem[rd_ptr]; rd_ptr increments and wraps.
  - valid_out=1 for exactly the next cycle; otherwise valid_out=0.
  - data_out holds its last value when no pop occurs.
- **Read latency:** 1 clock from pop to data_out/valid_out. No fall-through: a pop on an empty FIFO that receives a simultaneous push is rejected.
- **count update:**
  - +1 if push_ok only; -1 if pop_ok only.
  - Unchanged if both or neither.
  - Full with push and pop: both accepted, count stays DEPTH.
- **error:**
  - Set on push && !push_ok (overflow) or pop && !pop_ok (underflow).
  - Stays 1 until reset or init.
  - Rejected operations change nothing else.
- **Flags:**
  - All flags are combinational from the registered count, so they change the cycle after the causing edge.
  - bajo/alto are compared live and zero-extended to ADDR_WIDTH+1 bits; a threshold change takes effect the same cycle.
  - alto==0 disables almost_full.
  - bajo > alto is legal; each flag is evaluated independently.
- **Wrap-around:** pointers wrap DEPTH-1 -> 0; ordering is preserved across the wrap.

Test Plan:
- **Reset:** assert reset=0 mid-stream with count=5 -> outputs immediately: count=0, empty=1, almost_empty=1, valid_out=0, error=0.
- **Fill, thresholds bajo=1, alto=6:**
  - push 0x01..0x08 on consecutive cycles.
  - almost_empty drops when count=2; almost_full rises when count=6; full=1 when count=8.
  - A 9th push sets error=1 with count still 8.
- **Drain and wrap:**
  - From full, pop 8 times, then push 0x2A, 0x15 and pop twice.
  - data_out sequence 0x01..0x08, then 0x2A, 0x15, each one cycle after its pop with valid_out=1.
  - Final state empty=1.
- **Simultaneous push/pop:**
  - At full, push 0x3F + pop -> count stays 8, old head output, 0x3F later read last, error=0.
  - At empty, push + pop -> count=1, valid_out=0, error=1.
- **Threshold change:**
  - count=6 with alto=7 -> almost_full=0.
  - Change alto to 6 -> almost_full=1 the same cycle.
  - alto=0 -> almost_full=0.
- **init:** with count=4 and error=1, pulse init while push=1 -> count=0, error=0, the push is discarded, empty=1.

Source files
------------

// File: rtl/fifo_umbral.sv
// Virtual-channel queue FIFO with live low/high threshold flags and a sticky
// overflow/underflow error. Read data is registered (one-cycle pop latency).
module fifo_umbral #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [ADDR_WIDTH-1:0] bajo,
    input  logic [ADDR_WIDTH-1:0] alto,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   count
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_reg;
    logic [ADDR_WIDTH-1:0] rd_ptr_reg;
    logic [ADDR_WIDTH:0]   count_reg;
    logic [DATA_WIDTH-1:0] data_out_reg;
    logic                  valid_out_reg;
    logic                  error_reg;

    logic pop_ok;
    logic push_ok;
    logic [ADDR_WIDTH:0] count_next;

    // A push into a full queue is only accepted when a pop frees the slot in the same edge.
    always_comb begin
        pop_ok  = pop && (count_reg != '0);
        push_ok = push && ((count_reg != FULL_COUNT) || pop_ok);
        count_next = count_reg;
        if (push_ok && !pop_ok) begin
            count_next = count_reg + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_next = count_reg - 1'b1;
        end
    end

    // Storage carries no reset so it can map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (push_ok && !init) begin
            mem[wr_ptr_reg] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            data_out_reg  <= '0;
            valid_out_reg <= 1'b0;
            error_reg     <= 1'b0;
        end else if (init) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            valid_out_reg <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg   <= rd_ptr_reg + 1'b1;
                data_out_reg <= mem[rd_ptr_reg];
            end
            valid_out_reg <= pop_ok;
            count_reg     <= count_next;
            if ((push && !push_ok) || (pop && !pop_ok)) begin
                error_reg <= 1'b1;
            end
        end
    end

    assign data_out     = data_out_reg;
    assign valid_out    = valid_out_reg;
    assign error        = error_reg;
    assign count        = count_reg;
    assign empty        = (count_reg == '0);
    assign full         = (count_reg == FULL_COUNT);
    assign almost_empty = (count_reg <= {1'b0, bajo});
    assign almost_full  = (alto != '0) && (count_reg >= {1'b0, alto});
endmodule

// File: tb/tb_fifo_umbral.sv
// Randomised and directed bench for fifo_umbral against a queue-based reference.
module tb_fifo_umbral;
    localparam int DW    = 6;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          init;
    logic [AW-1:0] bajo;
    logic [AW-1:0] alto;
    logic          push;
    logic [DW-1:0] data_in;
    logic          pop;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          empty;
    logic          full;
    logic          almost_empty;
    logic          almost_full;
    logic          error;
    logic [AW:0]   count;

    fifo_umbral #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .init(init), .bajo(bajo), .alto(alto),
        .push(push), .data_in(data_in), .pop(pop), .data_out(data_out),
        .valid_out(valid_out), .empty(empty), .full(full),
        .almost_empty(almost_empty), .almost_full(almost_full),
        .error(error), .count(count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: contents as an ordered queue plus the observable registers.
    logic [DW-1:0] q[$];
    logic          m_err;
    logic [DW-1:0] m_dout;
    logic          m_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        int c;
        c = q.size();
        check({tag, ".count"},        32'(count),        32'(c));
        check({tag, ".empty"},        32'(empty),        32'(c == 0));
        check({tag, ".full"},         32'(full),         32'(c == DEPTH));
        check({tag, ".almost_empty"}, 32'(almost_empty), 32'(c <= int'(bajo)));
        check({tag, ".almost_full"},  32'(almost_full),  32'((alto != 0) && (c >= int'(alto))));
        check({tag, ".error"},        32'(error),        32'(m_err));
        check({tag, ".valid_out"},    32'(valid_out),    32'(m_valid));
        check({tag, ".data_out"},     32'(data_out),     32'(m_dout));
    endtask

    // One clock transaction; inputs are driven 1 time unit after the previous edge.
    task automatic step(input string tag, input logic p, input logic [DW-1:0] d,
                        input logic r, input logic i);
        bit pok, wok;
        push = p; data_in = d; pop = r; init = i;
        pok = r && (q.size() > 0);
        wok = p && ((q.size() < DEPTH) || pok);
        @(posedge clk);
        if (i) begin
            q.delete();
            m_err   = 1'b0;
            m_valid = 1'b0;
        end else begin
            if (pok) m_dout = q.pop_front();
            m_valid = pok;
            if (wok) q.push_back(d);
            if ((p && !wok) || (r && !pok)) m_err = 1'b1;
        end
        #1;
        push = 1'b0; pop = 1'b0; init = 1'b0;
        $display("%0t %s push=%0b din=%02h pop=%0b init=%0b -> count=%0d dout=%02h v=%0b err=%0b",
                 $time, tag, p, d, r, i, count, data_out, valid_out, error);
        check_state(tag);
    endtask

    task automatic apply_reset(input string tag);
        reset = 1'b0;
        #1;
        q.delete();
        m_err = 1'b0; m_dout = '0; m_valid = 1'b0;
        $display("%0t %s reset asserted -> count=%0d empty=%0b", $time, tag, count, empty);
        check_state(tag);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1; init = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;
        bajo = 3'd1; alto = 3'd6;
        m_err = 1'b0; m_dout = '0; m_valid = 1'b0;
        #2;
        apply_reset("por");

        // Fill with thresholds bajo=1, alto=6.
        for (int k = 1; k <= 8; k++) step("fill", 1'b1, DW'(k), 1'b0, 1'b0);
        check("fill.full_at_8", 32'(full), 32'd1);

        // Full with push+pop: both accepted, old head read.
        step("full_pp", 1'b1, 6'h3F, 1'b1, 1'b0);
        check("full_pp.head", 32'(data_out), 32'h01);
        check("full_pp.noerr", 32'(error), 32'd0);

        // Overflow.
        step("ovf", 1'b1, 6'h11, 1'b0, 1'b0);
        check("ovf.error", 32'(error), 32'd1);
        check("ovf.count", 32'(count), 32'd8);

        // Drain across the wrap, then reuse wrapped slots.
        for (int k = 0; k < 8; k++) step("drain", 1'b0, '0, 1'b1, 1'b0);
        check("drain.last", 32'(data_out), 32'h3F);
        step("wrap", 1'b1, 6'h2A, 1'b0, 1'b0);
        step("wrap", 1'b1, 6'h15, 1'b0, 1'b0);
        step("wrap", 1'b0, '0, 1'b1, 1'b0);
        check("wrap.first", 32'(data_out), 32'h2A);
        step("wrap", 1'b0, '0, 1'b1, 1'b0);
        check("wrap.second", 32'(data_out), 32'h15);
        check("wrap.empty", 32'(empty), 32'd1);

        // Empty with push+pop: pop rejected, no fall-through.
        step("empty_pp", 1'b1, 6'h07, 1'b1, 1'b0);
        check("empty_pp.count", 32'(count), 32'd1);
        check("empty_pp.valid", 32'(valid_out), 32'd0);

        // init with count=4, error=1, push held high.
        for (int k = 0; k < 3; k++) step("pre_init", 1'b1, DW'(8'h20 + k), 1'b0, 1'b0);
        step("init", 1'b1, 6'h33, 1'b0, 1'b1);
        check("init.empty", 32'(empty), 32'd1);

        // Thresholds compared live.
        for (int k = 0; k < 6; k++) step("thr", 1'b1, DW'(k + 10), 1'b0, 1'b0);
        alto = 3'd7; #1;
        check("thr.alto7", 32'(almost_full), 32'd0);
        alto = 3'd6; #1;
        check("thr.alto6", 32'(almost_full), 32'd1);
        alto = 3'd0; #1;
        check("thr.alto0", 32'(almost_full), 32'd0);
        alto = 3'd6;

        // Asynchronous reset mid-stream at count=5.
        step("pre_rst", 1'b0, '0, 1'b1, 1'b0);
        check("pre_rst.count5", 32'(count), 32'd5);
        apply_reset("mid_rst");

        // Randomised traffic with random thresholds and occasional init.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                bajo = AW'($urandom);
                alto = AW'($urandom);
            end
            step("rand", 1'($urandom), DW'($urandom), 1'($urandom_range(0, 99) < 45),
                 ($urandom_range(0, 63) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, expected completion");
        $fatal(1);
    end
endmodule
